// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch
// and data access, with per-transaction timeout and pipeline hold outputs.
module mem_port_arbiter #(
    parameter int         TIMEOUT  = 16,
    parameter logic [3:0] MEM_NONE = 4'h0,
    parameter logic [3:0] MEM_LOAD = 4'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic [3:0]  dm_cmd,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_done,
    output logic [31:0] dm_rdata,
    output logic        err,
    output logic        mem_req,
    output logic [3:0]  mem_cmd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        st_if_hold,
    output logic        st_dm_hold
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic        last_dm_reg, last_dm_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        mem_req_reg, mem_req_next;
    logic [3:0]  mem_cmd_reg, mem_cmd_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic        if_done_reg, if_done_next;
    logic        dm_done_reg, dm_done_next;
    logic        err_reg, err_next;
    logic [31:0] if_rdata_reg, if_rdata_next;
    logic [31:0] dm_rdata_reg, dm_rdata_next;
    logic        grant_dm;
    logic        grant_if;

    // On a tie the requester that did not own the memory last time wins.
    assign grant_dm = dm_req & (~if_req | ~last_dm_reg);
    assign grant_if = if_req & ~grant_dm;

    always_comb begin
        state_next     = state_reg;
        last_dm_next   = last_dm_reg;
        cnt_next       = cnt_reg;
        mem_req_next   = mem_req_reg;
        mem_cmd_next   = mem_cmd_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        if_done_next   = 1'b0;
        dm_done_next   = 1'b0;
        err_next       = 1'b0;
        if_rdata_next  = if_rdata_reg;
        dm_rdata_next  = dm_rdata_reg;
        case (state_reg)
            IDLE: begin
                if (grant_dm) begin
                    state_next     = BUSY_DM;
                    last_dm_next   = 1'b1;
                    cnt_next       = 8'd0;
                    mem_req_next   = 1'b1;
                    mem_cmd_next   = dm_cmd;
                    mem_addr_next  = dm_addr;
                    mem_wdata_next = dm_wdata;
                end else if (grant_if) begin
                    state_next     = BUSY_IF;
                    last_dm_next   = 1'b0;
                    cnt_next       = 8'd0;
                    mem_req_next   = 1'b1;
                    mem_cmd_next   = MEM_LOAD;
                    mem_addr_next  = if_addr;
                    mem_wdata_next = 32'h0;
                end
            end
            BUSY_IF, BUSY_DM: begin
                // An ack in the final allowed cycle still counts as a normal completion.
                if (mem_ack || cnt_reg == CNT_LAST) begin
                    state_next   = RESP;
                    mem_req_next = 1'b0;
                    err_next     = ~mem_ack;
                    if (state_reg == BUSY_DM) begin
                        dm_done_next  = 1'b1;
                        dm_rdata_next = mem_ack ? mem_rdata : 32'h0;
                    end else begin
                        if_done_next  = 1'b1;
                        if_rdata_next = mem_ack ? mem_rdata : 32'h0;
                    end
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            last_dm_reg   <= 1'b0;
            cnt_reg       <= 8'd0;
            mem_req_reg   <= 1'b0;
            mem_cmd_reg   <= MEM_NONE;
            mem_addr_reg  <= 32'h0;
            mem_wdata_reg <= 32'h0;
            if_done_reg   <= 1'b0;
            dm_done_reg   <= 1'b0;
            err_reg       <= 1'b0;
            if_rdata_reg  <= 32'h0;
            dm_rdata_reg  <= 32'h0;
        end else begin
            state_reg     <= state_next;
            last_dm_reg   <= last_dm_next;
            cnt_reg       <= cnt_next;
            mem_req_reg   <= mem_req_next;
            mem_cmd_reg   <= mem_cmd_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            if_done_reg   <= if_done_next;
            dm_done_reg   <= dm_done_next;
            err_reg       <= err_next;
            if_rdata_reg  <= if_rdata_next;
            dm_rdata_reg  <= dm_rdata_next;
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_cmd   = mem_cmd_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_done   = if_done_reg;
    assign dm_done   = dm_done_reg;
    assign err       = err_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;

    // Bit 0 is fetch, bit 1 is data; a stage is held until its own done pulse.
    logic [1:0] req_vec;
    logic [1:0] done_vec;
    logic [1:0] hold_vec;

    assign req_vec  = {dm_req, if_req};
    assign done_vec = {dm_done_reg, if_done_reg};

    for (genvar gi = 0; gi < 2; gi++) begin : g_hold
        assign hold_vec[gi] = req_vec[gi] & ~done_vec[gi];
    end

    assign st_if_hold = hold_vec[0];
    assign st_dm_hold = hold_vec[1];

endmodule
